// File: rtl/cla_multiword_sequencer_if.sv
// Bundle of operand, adder-drive and result signals for the multiword add/sub sequencer.
// Both in_* and out_* are valid/ready: a transfer happens on a rising edge where valid && ready; the
// source holds valid and its payload stable until then, and ready never depends on valid.
interface cla_multiword_sequencer_if #(
  parameter int DATA  = 32,
  parameter int WORDS = 4
);
  localparam int W = DATA * WORDS;

  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic            in_cin;
  logic            in_sub;
  logic [DATA-1:0] add_a;
  logic [DATA-1:0] add_b;
  logic            add_cin;
  logic [DATA-1:0] add_sum;
  logic            add_cout;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_sum;
  logic            out_cout;
  logic            out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cla_multiword_sequencer.sv
// Iterates a wide add/sub through an external DATA-bit adder, one chunk per cycle, LSB chunk first,
// chaining the carry through carry_reg.
module cla_multiword_sequencer #(
  parameter int DATA  = 32,
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cla_multiword_sequencer_if.slave bus,
  output logic [1:0]              dbg_state
);
  localparam int W     = DATA * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             last_chunk;
  logic             ovf_next;

  assign accept     = (state == IDLE) && bus.in_valid;
  assign last_chunk = (state == RUN) && (idx == LAST_IDX);
  // The top result bit is still on the adder output during the final chunk, so overflow is latched then.
  assign ovf_next   = (a_reg[W-1] == b_reg[W-1]) && (bus.add_sum[DATA-1] != a_reg[W-1]);

  assign bus.out_sum  = sum_reg;
  assign bus.out_cout = cout_reg;
  assign bus.out_ovf  = ovf_reg;
  assign dbg_state    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    bus.add_cin   = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = RUN;
      end
      RUN: begin
        bus.add_a   = a_reg[idx*DATA +: DATA];
        bus.add_b   = b_reg[idx*DATA +: DATA];
        bus.add_cin = carry_reg;
        if (idx == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx       <= '0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1, so the inverted B and forced carry-in are stored up front.
      a_reg     <= bus.in_a;
      b_reg     <= bus.in_sub ? ~bus.in_b : bus.in_b;
      carry_reg <= bus.in_sub | bus.in_cin;
      idx       <= '0;
    end else if (state == RUN) begin
      sum_reg[idx*DATA +: DATA] <= bus.add_sum;
      carry_reg                 <= bus.add_cout;
      if (last_chunk) begin
        cout_reg <= bus.add_cout;
        ovf_reg  <= ovf_next;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end
endmodule
